// File: rtl/mem_pkg.sv
// Shared definitions for the MIPS memory-access stage: access-size encodings,
// lane-mask type, reset value and the lane-mask helper.
package mem_pkg;

    localparam logic [2:0] OP_W  = 3'd0;
    localparam logic [2:0] OP_HU = 3'd1;
    localparam logic [2:0] OP_HS = 3'd2;
    localparam logic [2:0] OP_BU = 3'd3;
    localparam logic [2:0] OP_BS = 3'd4;

    localparam logic [31:0] DM_RESET_VAL = 32'd0;

    typedef logic [3:0] lane_mask_t;

    // Byte lanes touched by an access; encodings 5-7 fall through to word.
    function automatic lane_mask_t lane_mask(input logic [2:0] op, input logic [1:0] lo);
        lane_mask_t m;
        m = 4'b1111;
        case (op)
            OP_HU, OP_HS: m = lo[1] ? 4'b1100 : 4'b0011;
            OP_BU, OP_BS: m = 4'b0001 << lo;
            default:      m = 4'b1111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dm_ram.sv
// Data memory array: byte-enable synchronous write, synchronous clear, asynchronous read.
module dm_ram
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  lane_mask_t        be,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= DM_RESET_VAL;
            end
        end else if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage.sv
// MIPS memory-access stage: lane-masked stores, extended loads, committed-store counter.
// Optional sticky misalignment exception when DM_ALIGN_CHECK_EN is defined.
module mem_stage
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ALU_OUT_M,
    input  logic [31:0] WRITE_DATA_M,
    input  logic [31:0] PC_M,
    input  logic        MEM_WRITE_M,
    input  logic        MEM_READ_M,
    input  logic [2:0]  MEM_OP_M,
    output logic [31:0] Real_MEM_OUT_M,
    output logic [31:0] STORE_CNT,
    output logic        ADDR_EXC,
    output logic [31:0] EXC_PC
);

    logic              is_half;
    logic              is_byte;
    logic              is_word;
    logic              in_range;
    logic              misaligned;
    logic [1:0]        lo;
    logic [ADDR_W-1:0] word_idx;
    lane_mask_t        mask;
    logic [31:0]       wdata_lanes;
    logic [31:0]       rdata;
    logic              store_commit;
    logic [31:0]       store_cnt;

    assign is_half  = (MEM_OP_M == OP_HU) || (MEM_OP_M == OP_HS);
    assign is_byte  = (MEM_OP_M == OP_BU) || (MEM_OP_M == OP_BS);
    assign is_word  = !is_half && !is_byte;
    assign in_range = (ALU_OUT_M[31:ADDR_W+2] == '0);
    assign word_idx = ALU_OUT_M[ADDR_W+1:2];

`ifdef DM_ALIGN_CHECK_EN
    assign lo         = ALU_OUT_M[1:0];
    assign misaligned = (is_word && (lo != 2'b00)) || (is_half && lo[0]);
`else
    // Without checking, low bits below the access size are simply ignored.
    assign lo         = is_word ? 2'b00 : (is_half ? {ALU_OUT_M[1], 1'b0} : ALU_OUT_M[1:0]);
    assign misaligned = 1'b0;
`endif

    assign mask         = lane_mask(MEM_OP_M, lo);
    assign store_commit = MEM_WRITE_M && in_range && !misaligned && !reset;

    always_comb begin
        wdata_lanes = WRITE_DATA_M;
        if (is_half) begin
            wdata_lanes = {2{WRITE_DATA_M[15:0]}};
        end else if (is_byte) begin
            wdata_lanes = {4{WRITE_DATA_M[7:0]}};
        end
    end

    dm_ram #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .ADDR_W     (ADDR_W)
    ) u_dm_ram (
        .clk  (clk),
        .reset(reset),
        .we   (store_commit),
        .be   (mask),
        .addr (word_idx),
        .wdata(wdata_lanes),
        .rdata(rdata)
    );

    // Load extraction sees pre-store data, so a same-cycle store is invisible here.
    always_comb begin
        logic [15:0] half_val;
        logic [7:0]  byte_val;
        half_val       = lo[1] ? rdata[31:16] : rdata[15:0];
        byte_val       = rdata[8*lo +: 8];
        Real_MEM_OUT_M = 32'd0;
        if (in_range && !misaligned) begin
            case (MEM_OP_M)
                OP_HU:   Real_MEM_OUT_M = {16'd0, half_val};
                OP_HS:   Real_MEM_OUT_M = {{16{half_val[15]}}, half_val};
                OP_BU:   Real_MEM_OUT_M = {24'd0, byte_val};
                OP_BS:   Real_MEM_OUT_M = {{24{byte_val[7]}}, byte_val};
                default: Real_MEM_OUT_M = rdata;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            store_cnt <= 32'd0;
        end else if (store_commit) begin
            store_cnt <= store_cnt + 32'd1;
        end
    end

    assign STORE_CNT = store_cnt;

`ifdef DM_ALIGN_CHECK_EN
    logic        exc_flag;
    logic [31:0] exc_pc_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            exc_flag <= 1'b0;
            exc_pc_q <= 32'd0;
        end else if (misaligned && (MEM_READ_M || MEM_WRITE_M) && !exc_flag) begin
            exc_flag <= 1'b1;
            exc_pc_q <= PC_M;
        end
    end

    assign ADDR_EXC = exc_flag;
    assign EXC_PC   = exc_pc_q;
`else
    logic unused_inputs;
    assign unused_inputs = ^{PC_M, MEM_READ_M};
    assign ADDR_EXC      = 1'b0;
    assign EXC_PC        = 32'd0;
`endif

endmodule
